// File: rtl/rv32i_memory_pkg.sv
// rtl/rv32i_memory_pkg.sv - shared encodings for the rv32i memory stage
package rv32i_memory_pkg;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;

  localparam logic [2:0] LS_LB  = 3'b000;
  localparam logic [2:0] LS_LH  = 3'b001;
  localparam logic [2:0] LS_LW  = 3'b010;
  localparam logic [2:0] LS_LBU = 3'b100;
  localparam logic [2:0] LS_LHU = 3'b101;

  localparam logic [1:0] RS_ALU  = 2'b00;
  localparam logic [1:0] RS_LOAD = 2'b01;
  localparam logic [1:0] RS_PC4  = 2'b10;

  // Map a load funct3 onto the store-size encoding so both share one size path.
  function automatic logic [1:0] load_to_size(input logic [2:0] ls);
    case (ls[1:0])
      2'b00:   return MW_BYTE;
      2'b01:   return MW_HALF;
      default: return MW_WORD;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_memory_if.sv
// rtl/rv32i_memory_if.sv - data memory bus between the memory stage and dmem
interface rv32i_memory_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/rv32i_memory_load_ext.sv
// rtl/rv32i_memory_load_ext.sv - byte/half select and sign/zero extend of load data
module load_ext
  import rv32i_memory_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_size,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (load_size)
      LS_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LS_LH:   data = {{16{half_sel[15]}}, half_sel};
      LS_LBU:  data = {24'd0, byte_sel};
      LS_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/rv32i_memory.sv
// rtl/rv32i_memory.sv - rv32i memory stage: dmem handshake, stall/abort, DM/WB register
module rv32i_memory
  import rv32i_memory_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWriteM,
  input  logic [1:0]         ResultSrcM,
  input  logic [1:0]         MemWriteM,
  input  logic [2:0]         LoadSizeM,
  input  logic [31:0]        ALUResultM,
  input  logic [31:0]        WriteDataM,
  input  logic [31:0]        PCPlus4M,
  input  logic [4:0]         RdM,
  rv32i_memory_if.master     bus,
  output logic               StallM,
  output logic               MisalignM,
  output logic               BusErrM,
  output logic               RegWriteW,
  output logic [1:0]         ResultSrcW,
  output logic [4:0]         RdW,
  output logic [31:0]        ALUResultW,
  output logic [31:0]        ReadDataW,
  output logic [31:0]        PCPlus4W
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  mem_state_t  state, state_next;
  logic [CW-1:0] cnt;
  logic [CW:0]   cnt_inc;
  logic        is_store, access, misalign_raw, go, timeout;
  logic [1:0]  size;
  logic [31:0] load_data;

  assign is_store = (MemWriteM != MW_NONE);
  assign access   = is_store || (ResultSrcM == RS_LOAD);
  assign size     = is_store ? MemWriteM : load_to_size(LoadSizeM);

  always_comb begin
    bus.dmem_be    = 4'b1111;
    bus.dmem_wdata = WriteDataM;
    misalign_raw   = 1'b0;
    case (size)
      MW_BYTE: begin
        bus.dmem_be    = 4'b0001 << ALUResultM[1:0];
        bus.dmem_wdata = {4{WriteDataM[7:0]}};
      end
      MW_HALF: begin
        bus.dmem_be    = 4'b0011 << ALUResultM[1:0];
        bus.dmem_wdata = {2{WriteDataM[15:0]}};
        misalign_raw   = ALUResultM[0];
      end
      default: misalign_raw = (ALUResultM[1:0] != 2'b00);
    endcase
  end

  assign go            = access && !misalign_raw;
  assign bus.dmem_we   = is_store;
  assign bus.dmem_addr = {ALUResultM[31:2], 2'b00};

  // cnt counts WAIT cycles already spent; the IDLE request cycle counts as the first wait.
  assign cnt_inc = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};

  always_comb begin
    state_next = state;
    timeout    = (state == WAIT) && (cnt_inc >= (CW+1)'(TIMEOUT));
    case (state)
      IDLE: if (go && !bus.dmem_ready) state_next = WAIT;
      WAIT: if (!go || bus.dmem_ready || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state == WAIT) ? cnt_inc[CW-1:0] : '0;
    end
  end

  assign bus.dmem_req = rst && go;
  assign StallM       = rst && go && !bus.dmem_ready && !timeout;
  assign MisalignM    = rst && access && misalign_raw;
  assign BusErrM      = rst && go && !bus.dmem_ready && timeout;

  load_ext u_load_ext (
    .rdata     (bus.dmem_rdata),
    .offset    (ALUResultM[1:0]),
    .load_size (LoadSizeM),
    .data      (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
      ALUResultW <= 32'd0;
      ReadDataW  <= 32'd0;
      PCPlus4W   <= 32'd0;
    end else begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= load_data;
      PCPlus4W   <= PCPlus4M;
      if (StallM) begin
        RegWriteW  <= 1'b0;
        ResultSrcW <= RS_ALU;
        RdW        <= 5'd0;
      end else begin
        RegWriteW  <= RegWriteM && !MisalignM && !BusErrM;
        ResultSrcW <= ResultSrcM;
        RdW        <= RdM;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_memory.sv
// tb/tb_rv32i_memory.sv - directed self-checking bench for rv32i_memory
module tb_rv32i_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM, MemWriteM;
  logic [2:0]  LoadSizeM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        StallM, MisalignM, BusErrM, RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;

  int passed = 0;
  int total  = 0;
  int stalls;
  int errs;

  rv32i_memory_if bus ();

  rv32i_memory #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .LoadSizeM(LoadSizeM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM), .bus(bus),
    .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic drive(input logic rw, input logic [1:0] rs, input logic [1:0] mw,
                       input logic [2:0] ls, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd);
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; LoadSizeM = ls;
    ALUResultM = a; WriteDataM = wd; RdM = rd; PCPlus4M = a + 32'd4;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 3'b000, 32'd0, 32'd0, 5'd0);
    bus.dmem_rdata = 32'd0;
    bus.dmem_ready = 1'b0;
    next_edge();
    check("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    check("rst_stall", {31'd0, StallM}, 32'd0);
    check("rst_regwrite", {31'd0, RegWriteW}, 32'd0);
    check("rst_alu", ALUResultW, 32'd0);
    rst = 1'b1;

    // LB at byte 3, ready in the same cycle
    drive(1'b1, 2'b01, 2'b00, 3'b000, 32'h103, 32'd0, 5'd5);
    bus.dmem_rdata = 32'h80FF_FF7F; bus.dmem_ready = 1'b1;
    @(negedge clk);
    check("lb_req", {31'd0, bus.dmem_req}, 32'd1);
    check("lb_be", {28'd0, bus.dmem_be}, 32'h8);
    check("lb_addr", bus.dmem_addr, 32'h100);
    check("lb_stall", {31'd0, StallM}, 32'd0);
    next_edge();
    check("lb_data", ReadDataW, 32'hFFFF_FF80);
    check("lb_rd", {27'd0, RdW}, 32'd5);
    check("lb_regwrite", {31'd0, RegWriteW}, 32'd1);

    // LH and LHU on the upper half
    drive(1'b1, 2'b01, 2'b00, 3'b001, 32'h102, 32'd0, 5'd6);
    bus.dmem_rdata = 32'h8001_1234;
    next_edge();
    check("lh_data", ReadDataW, 32'hFFFF_8001);
    drive(1'b1, 2'b01, 2'b00, 3'b101, 32'h102, 32'd0, 5'd6);
    next_edge();
    check("lhu_data", ReadDataW, 32'h0000_8001);
    drive(1'b1, 2'b01, 2'b00, 3'b100, 32'h101, 32'd0, 5'd6);
    bus.dmem_rdata = 32'h0000_F000;
    next_edge();
    check("lbu_data", ReadDataW, 32'h0000_00F0);

    // SB and SW with same-cycle ready
    drive(1'b0, 2'b00, 2'b01, 3'b000, 32'h101, 32'h0000_00A5, 5'd0);
    @(negedge clk);
    check("sb_be", {28'd0, bus.dmem_be}, 32'h2);
    check("sb_wdata", bus.dmem_wdata, 32'hA5A5_A5A5);
    check("sb_we", {31'd0, bus.dmem_we}, 32'd1);
    next_edge();
    drive(1'b0, 2'b00, 2'b11, 3'b000, 32'h100, 32'h1122_3344, 5'd0);
    @(negedge clk);
    check("sw_be", {28'd0, bus.dmem_be}, 32'hF);
    check("sw_wdata", bus.dmem_wdata, 32'h1122_3344);
    next_edge();

    // SH with ready after three wait cycles
    drive(1'b0, 2'b00, 2'b10, 3'b000, 32'h102, 32'h1234_ABCD, 5'd0);
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      bus.dmem_ready = (i == 3);
      @(negedge clk);
      check($sformatf("sh_be_%0d", i), {28'd0, bus.dmem_be}, 32'hC);
      check($sformatf("sh_wdata_%0d", i), bus.dmem_wdata, 32'hABCD_ABCD);
      check($sformatf("sh_req_%0d", i), {31'd0, bus.dmem_req}, 32'd1);
      if (StallM) stalls++;
      next_edge();
      check($sformatf("sh_regwrite_%0d", i), {31'd0, RegWriteW}, 32'd0);
    end
    check("sh_stall_cycles", stalls, 32'd3);

    // Misaligned LW
    drive(1'b1, 2'b01, 2'b00, 3'b010, 32'h101, 32'd0, 5'd7);
    @(negedge clk);
    check("mis_req", {31'd0, bus.dmem_req}, 32'd0);
    check("mis_flag", {31'd0, MisalignM}, 32'd1);
    check("mis_stall", {31'd0, StallM}, 32'd0);
    next_edge();
    check("mis_regwrite", {31'd0, RegWriteW}, 32'd0);
    check("mis_rd", {27'd0, RdW}, 32'd7);

    // Plain ALU op: no access, passes straight through
    drive(1'b1, 2'b00, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'd0, 5'd3);
    @(negedge clk);
    check("alu_misalign", {31'd0, MisalignM}, 32'd0);
    check("alu_req", {31'd0, bus.dmem_req}, 32'd0);
    next_edge();
    check("alu_result", ALUResultW, 32'hDEAD_BEEF);
    check("alu_pc4", PCPlus4W, 32'hDEAD_BEF3);
    check("alu_regwrite", {31'd0, RegWriteW}, 32'd1);

    // LHU never acknowledged: four stall cycles then a bus error
    drive(1'b1, 2'b01, 2'b00, 3'b101, 32'h200, 32'd0, 5'd8);
    bus.dmem_ready = 1'b0;
    stalls = 0; errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("to_stall_%0d", i), {31'd0, StallM}, (i < 4) ? 32'd1 : 32'd0);
      check($sformatf("to_buserr_%0d", i), {31'd0, BusErrM}, (i == 4) ? 32'd1 : 32'd0);
      if (StallM) stalls++;
      if (BusErrM) errs++;
      next_edge();
    end
    check("to_stall_cycles", stalls, 32'd4);
    check("to_err_pulses", errs, 32'd1);
    check("to_regwrite", {31'd0, RegWriteW}, 32'd0);
    check("to_rd", {27'd0, RdW}, 32'd8);
    drive(1'b1, 2'b01, 2'b00, 3'b010, 32'h204, 32'd0, 5'd4);
    bus.dmem_ready = 1'b1; bus.dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("to_after_stall", {31'd0, StallM}, 32'd0);
    check("to_after_buserr", {31'd0, BusErrM}, 32'd0);
    next_edge();
    check("to_after_data", ReadDataW, 32'h5555_AAAA);
    check("to_after_regwrite", {31'd0, RegWriteW}, 32'd1);

    // Reset asserted mid-WAIT, then a normal access
    drive(1'b1, 2'b01, 2'b00, 3'b010, 32'h300, 32'd0, 5'd9);
    bus.dmem_ready = 1'b0;
    next_edge();
    check("rw_stall_pre", {31'd0, StallM}, 32'd1);
    rst = 1'b0;
    #1;
    check("rw_req", {31'd0, bus.dmem_req}, 32'd0);
    check("rw_stall", {31'd0, StallM}, 32'd0);
    check("rw_alu", ALUResultW, 32'd0);
    check("rw_pc4", PCPlus4W, 32'd0);
    check("rw_rdata", ReadDataW, 32'd0);
    next_edge();
    rst = 1'b1;
    bus.dmem_ready = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("rw_post_req", {31'd0, bus.dmem_req}, 32'd1);
    check("rw_post_stall", {31'd0, StallM}, 32'd0);
    next_edge();
    check("rw_post_data", ReadDataW, 32'hCAFE_F00D);
    check("rw_post_rd", {27'd0, RdW}, 32'd9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rv32i_memory.md
RV32I_MEMORY -- requirements
Module: rv32i_memory

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum dmem_ready wait cycles before an access is aborted.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 RegWriteM  in  1  register write enable from execute stage.
REQ-005 ResultSrcM  in  2  result select: 00 ALU, 01 load data, 10 PC+4; 01 marks a load.
REQ-006 MemWriteM  in  2  store size: 00 none, 01 byte, 10 half, 11 word.
REQ-007 LoadSizeM  in  3  funct3 load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 ALUResultM  in  32  effective address / ALU result.
REQ-009 WriteDataM  in  32  store data, LSB-aligned.
REQ-010 PCPlus4M  in  32  return address.
REQ-011 RdM  in  5  destination register.
REQ-012 dmem_req  out  1  bus request, held until dmem_ready.
REQ-013 dmem_we  out  1  1 = write.
REQ-014 dmem_addr  out  32  word address: ALUResultM with bits [1:0] forced to 0.
REQ-015 dmem_be  out  4  byte enables.
REQ-016 dmem_wdata  out  32  lane-replicated store data.
REQ-017 dmem_rdata  in  32  read word, valid when dmem_ready=1.
REQ-018 dmem_ready  in  1  transfer-complete strobe.
REQ-019 StallM  out  1  to hazard unit: freeze PC, IF/ID, ID/IE and the IE/DM register.
REQ-020 MisalignM  out  1  one-cycle pulse on a misaligned access.
REQ-021 BusErrM  out  1  one-cycle pulse on an access timeout.
REQ-022 RegWriteW, ResultSrcW, RdW  out  1/2/5  registered controls to writeback.
REQ-023 ALUResultW, ReadDataW, PCPlus4W  out  32 each  registered data to writeback.

Function
REQ-024 Access SHALL exist when MemWriteM!=00 (store) or ResultSrcM==01 (load); otherwise dmem_req SHALL be 0 and the DM/WB register SHALL load every cycle.
REQ-025 Access size rules: byte = be 0001<<a[1:0]; half = be 0011<<a[1:0]; word = be 1111.
- Store data: byte replicated x4; half replicated x2; word as-is.
- Load size uses LoadSizeM[1:0].
REQ-026 Misaligned: half with a[0]=1, or word with a[1:0]!=00.
- dmem_req SHALL be 0 and MisalignM SHALL be 1 for that cycle.
- The W register SHALL capture the instruction with RegWriteW=0; no stall.
REQ-027 FSM states: IDLE, WAIT.
- IDLE: an aligned access SHALL assert dmem_req combinationally.
- dmem_ready=1 in the same cycle completes the access with zero stall.
- Otherwise StallM=1 and the FSM SHALL go to WAIT.
REQ-028 WAIT: dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata SHALL stay stable; StallM=1 until the dmem_ready cycle.
- On that cycle StallM=0 and the FSM SHALL return to IDLE.
REQ-029 StallM SHALL equal access & aligned & !dmem_ready & !timeout; it SHALL be purely combinational, with no added latency.
REQ-030 While StallM=1, the W register SHALL load a bubble: RegWriteW=0, RdW=0, ResultSrcW=00.
REQ-031 Load extract: select byte/half by a[1:0] from dmem_rdata; sign-extend for LB/LH, zero-extend for LBU/LHU.
- The result SHALL be registered into ReadDataW on the completion edge, 1-cycle latency.
REQ-032 Wait counter: 8-bit minimum width; cleared in IDLE; incremented each WAIT cycle.
- At TIMEOUT the access SHALL abort: BusErrM=1, StallM=0, W capture with RegWriteW=0, FSM to IDLE.
REQ-033 Stores SHALL still pass RegWriteM through; the decoder guarantees it is 0 for stores, and this block does not mask it except per REQ-026, REQ-030 and REQ-032.

Reset
REQ-034 rst=0 SHALL force the FSM to IDLE, clear the counter, and clear all W outputs to 0.
- dmem_req, StallM, MisalignM and BusErrM SHALL read 0 while rst=0, including mid-WAIT.
REQ-035 After release, the first rising edge SHALL behave as IDLE.

Structure
REQ-036 A shared package SHALL hold the FSM state enum and the MemWrite, LoadSize and ResultSrc encodings.
REQ-037 Load extract/extend SHALL be a combinational sub-module, load_ext.

Verification
REQ-038 LB, a=0x103, rdata=0x80FF_FF7F, ready same cycle -> be=1000, StallM never 1, ReadDataW=0xFFFF_FF80 next edge.
REQ-039 SH, a=0x102, WriteDataM=0x1234_ABCD, ready after 3 cycles -> be=1100, wdata=0xABCD_ABCD stable 4 cycles, StallM=1 for 3 cycles, RegWriteW=0 throughout.
REQ-040 LW, a=0x101 -> dmem_req=0, MisalignM=1 one cycle, RegWriteW=0 next edge.
REQ-041 LHU, a=0x200, ready never, TIMEOUT=4 -> StallM=1 for 4 cycles, BusErrM pulse, FSM IDLE.
REQ-042 rst low during WAIT -> dmem_req=0, StallM=0, all W outputs 0 immediately; next aligned access serviced normally.
